// File: rtl/aes_job_sched.sv
// aes_job_sched: round-robin encrypt/decrypt job scheduler sequencing AES engine kld/ld/done; key cache under AES_KEY_CACHE_EN
module aes_job_sched #(
  parameter int KEY_EXP_CYCLES = 10,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_mode,
  input  logic [127:0] req0_key,
  input  logic [127:0] req0_text,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_mode,
  input  logic [127:0] req1_key,
  input  logic [127:0] req1_text,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic         resp_err,
  output logic [127:0] resp_text,
  output logic         eng_mode,
  output logic         eng_kld,
  output logic         eng_ld,
  output logic [127:0] eng_key,
  output logic [127:0] eng_text_in,
  input  logic [127:0] eng_text_out,
  input  logic         eng_done,
  output logic         busy
);
  localparam int CW = $clog2((KEY_EXP_CYCLES > DONE_TIMEOUT ? KEY_EXP_CYCLES : DONE_TIMEOUT) + 1);
  typedef enum logic [2:0] {IDLE, KLD, KWAIT, LD, RUN, RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last_q, last_d;
  logic gnt, acc, hit, gmode;
  logic [127:0] gkey, gtext;
  logic eng_mode_q, eng_mode_d, eng_kld_q, eng_kld_d, eng_ld_q, eng_ld_d;
  logic [127:0] eng_key_q, eng_key_d, eng_text_q, eng_text_d;
  logic resp_valid_q, resp_valid_d, resp_id_q, resp_id_d, resp_err_q, resp_err_d;
  logic [127:0] resp_text_q, resp_text_d;
  logic busy_q, busy_d;
`ifdef AES_KEY_CACHE_EN
  logic ck_vld_q, ck_vld_d;
  logic [127:0] ck_key_q, ck_key_d;
`endif
  always_comb begin
    gnt = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    acc = (state_q == IDLE) & (req0_valid | req1_valid);
    gmode = gnt ? req1_mode : req0_mode;
    gkey = gnt ? req1_key : req0_key;
    gtext = gnt ? req1_text : req0_text;
`ifdef AES_KEY_CACHE_EN
    hit = ck_vld_q & (gkey == ck_key_q);
    ck_vld_d = ck_vld_q;
    ck_key_d = ck_key_q;
`else
    hit = 1'b0;
`endif
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    eng_mode_d = eng_mode_q;
    eng_key_d = eng_key_q;
    eng_text_d = eng_text_q;
    resp_id_d = resp_id_q;
    resp_err_d = resp_err_q;
    resp_text_d = resp_text_q;
    case (state_q)
      IDLE: if (acc) begin
        last_d = gnt;
        resp_id_d = gnt;
        eng_mode_d = gmode;
        eng_key_d = gkey;
        eng_text_d = gtext;
        state_d = (gmode & ~hit) ? KLD : LD;
      end
      KLD: begin
        state_d = KWAIT;
        cnt_d = '0;
      end
      KWAIT: if (cnt_q == CW'(KEY_EXP_CYCLES - 1)) begin
        state_d = LD;
`ifdef AES_KEY_CACHE_EN
        ck_vld_d = 1'b1;
        ck_key_d = eng_key_q;
`endif
      end else cnt_d = cnt_q + 1'b1;
      LD: begin
        state_d = RUN;
        cnt_d = '0;
      end
      RUN: if (eng_done) begin
        resp_text_d = eng_text_out;
        resp_err_d = 1'b0;
        state_d = RESP;
      end else if (cnt_q == CW'(DONE_TIMEOUT - 1)) begin
        resp_text_d = '0;
        resp_err_d = 1'b1;
        state_d = RESP;
`ifdef AES_KEY_CACHE_EN
        ck_vld_d = 1'b0;
`endif
      end else cnt_d = cnt_q + 1'b1;
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    eng_kld_d = state_d == KLD;
    eng_ld_d = state_d == LD;
    resp_valid_d = state_d == RESP;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= 1'b1;
      eng_mode_q <= 1'b0;
      eng_kld_q <= 1'b0;
      eng_ld_q <= 1'b0;
      eng_key_q <= '0;
      eng_text_q <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q <= 1'b0;
      resp_err_q <= 1'b0;
      resp_text_q <= '0;
      busy_q <= 1'b0;
`ifdef AES_KEY_CACHE_EN
      ck_vld_q <= 1'b0;
      ck_key_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      eng_mode_q <= eng_mode_d;
      eng_kld_q <= eng_kld_d;
      eng_ld_q <= eng_ld_d;
      eng_key_q <= eng_key_d;
      eng_text_q <= eng_text_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q <= resp_id_d;
      resp_err_q <= resp_err_d;
      resp_text_q <= resp_text_d;
      busy_q <= busy_d;
`ifdef AES_KEY_CACHE_EN
      ck_vld_q <= ck_vld_d;
      ck_key_q <= ck_key_d;
`endif
    end
  end
  assign req0_ready = acc & ~gnt;
  assign req1_ready = acc & gnt;
  assign resp_valid = resp_valid_q;
  assign resp_id = resp_id_q;
  assign resp_err = resp_err_q;
  assign resp_text = resp_text_q;
  assign eng_mode = eng_mode_q;
  assign eng_kld = eng_kld_q;
  assign eng_ld = eng_ld_q;
  assign eng_key = eng_key_q;
  assign eng_text_in = eng_text_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_aes_job_sched.sv
// tb_aes_job_sched: randomized scoreboard bench for aes_job_sched against a job-level reference model
module tb_aes_job_sched;
  localparam int KE = 10;
  localparam int DT = 64;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  typedef struct packed {logic m; logic [127:0] k; logic [127:0] t;} job_t;
  typedef struct packed {logic id; logic err; logic [127:0] text;} rsp_t;
  logic clk, rst, resp_ready, eng_done;
  logic [127:0] eng_text_out;
  logic rv[2], rm[2], dbusy[2];
  logic [127:0] rk[2], rt[2];
  logic req0_ready, req1_ready, resp_valid, resp_id, resp_err, eng_mode, eng_kld, eng_ld, busy;
  logic [127:0] resp_text, eng_key, eng_text_in;
  job_t jq0[$], jq1[$];
  rsp_t sb[$];
  logic gseq[$];
  int checks = 0, failures = 0, kld_cnt = 0, eng_cfg = 0;
  logic rr_hold = 0;
  aes_job_sched #(.KEY_EXP_CYCLES(KE), .DONE_TIMEOUT(DT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(rv[0]), .req0_ready(req0_ready), .req0_mode(rm[0]), .req0_key(rk[0]), .req0_text(rt[0]),
    .req1_valid(rv[1]), .req1_ready(req1_ready), .req1_mode(rm[1]), .req1_key(rk[1]), .req1_text(rt[1]),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_err(resp_err), .resp_text(resp_text),
    .eng_mode(eng_mode), .eng_kld(eng_kld), .eng_ld(eng_ld), .eng_key(eng_key), .eng_text_in(eng_text_in),
    .eng_text_out(eng_text_out), .eng_done(eng_done), .busy(busy)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  function automatic logic [127:0] ref_aes(input logic m, input logic [127:0] k, input logic [127:0] t);
    if (k == K0 && !m && t == P0) return C0;
    if (k == K0 && m && t == C0) return P0;
    return t ^ {k[63:0], k[127:64]} ^ {128{m}};
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic job_t mk(input logic m, input logic [127:0] k, input logic [127:0] t);
    return {m, k, t};
  endfunction
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic drv(input int n);
    job_t j;
    int w;
    logic has;
    rv[n] = 0; rm[n] = 0; rk[n] = '0; rt[n] = '0; dbusy[n] = 0;
    forever begin
      @(posedge clk); #1;
      has = (n != 0) ? (jq1.size() != 0) : (jq0.size() != 0);
      if (!has) begin
        rv[n] = 0;
        dbusy[n] = 0;
      end else begin
        if (n != 0) j = jq1.pop_front();
        else j = jq0.pop_front();
        dbusy[n] = 1; rv[n] = 1; rm[n] = j.m; rk[n] = j.k; rt[n] = j.t;
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!((n != 0) ? req1_ready : req0_ready) && w < 5000);
      end
    end
  endtask
  initial fork
    drv(0);
    drv(1);
  join
  initial begin
    resp_ready = 0;
    forever begin
      @(posedge clk); #1;
      resp_ready = rr_hold ? 1'b0 : 1'($urandom_range(0, 3) != 0);
    end
  end
  initial begin : engine
    logic [127:0] res;
    int k;
    eng_done = 0;
    eng_text_out = '0;
    forever begin
      @(negedge clk);
      if (eng_ld && eng_cfg != 1) begin
        res = ref_aes(eng_mode, eng_key, eng_text_in);
        k = eng_cfg == 2 ? 30 : eng_cfg == 3 ? DT : eng_cfg == 4 ? DT + 1 : int'($urandom_range(1, 5));
        repeat (k) @(posedge clk);
        #1;
        eng_done = 1;
        eng_text_out = res;
        @(posedge clk); #1;
        eng_done = 0;
        eng_text_out = rnd128();
      end
    end
  end
  initial begin : monitor
    int cyc, exp_kld, exp_ld, exp_resp, ld_at;
    logic m_last, m_busy, c_vld, prev_v, prev_rdy, id, hit, err;
    logic [127:0] c_key;
    logic [256:0] cur_job;
    rsp_t prev, e;
    cyc = 0; exp_kld = -1; exp_ld = -1; exp_resp = -1; ld_at = 0;
    m_last = 1; m_busy = 0; c_vld = 0; c_key = '0; prev_v = 0; prev_rdy = 0; prev = '0; cur_job = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        sb.delete();
        exp_kld = -1; exp_ld = -1; exp_resp = -1;
        m_last = 1; m_busy = 0; c_vld = 0; prev_v = 0;
      end else begin
        chk("busy", busy, m_busy);
        if (req0_ready || req1_ready) begin
          chk("one_ready", {req0_ready, req1_ready} != 2'b11, 1);
          id = req1_ready;
          if (rv[0] && rv[1]) chk("rr_grant", id, !m_last);
          m_last = id;
          gseq.push_back(id);
          hit = 0;
          err = eng_cfg == 1 || eng_cfg == 4;
`ifdef AES_KEY_CACHE_EN
          hit = rm[id] && c_vld && c_key == rk[id];
          if (rm[id] && !hit) begin
            c_vld = 1;
            c_key = rk[id];
          end
          if (err) c_vld = 0;
`endif
          sb.push_back({id, err, err ? 128'h0 : ref_aes(rm[id], rk[id], rt[id])});
          cur_job = {rm[id], rk[id], rt[id]};
          exp_kld = (rm[id] && !hit) ? cyc + 1 : -1;
          exp_ld = (rm[id] && !hit) ? cyc + 2 + KE : cyc + 1;
          m_busy = 1;
        end
        if (eng_kld) begin
          chk("kld_time", cyc, exp_kld);
          exp_kld = -1;
          kld_cnt++;
        end
        if (eng_ld) begin
          chk("ld_time", cyc, exp_ld);
          chk("eng_regs", {eng_mode, eng_key, eng_text_in}, cur_job);
          exp_ld = -1;
          ld_at = cyc;
          exp_resp = cyc + 1 + DT;
        end
        if (eng_done && exp_resp > 0 && cyc > ld_at && cyc < exp_resp) exp_resp = cyc + 1;
        if (resp_valid && !prev_v) begin
          chk("resp_time", cyc, exp_resp);
          exp_resp = -1;
        end
        if (resp_valid) begin
          chk("ready_in_resp", {req0_ready, req1_ready}, 0);
          if (prev_v && !prev_rdy) chk("resp_stable", {resp_id, resp_err, resp_text}, prev);
        end
        if (resp_valid && resp_ready) begin
          if (sb.size() == 0) chk("resp_unexpected", resp_valid, 0);
          else begin
            e = sb.pop_front();
            chk("resp", {resp_id, resp_err, resp_text}, e);
          end
          m_busy = 0;
        end
        prev_v = resp_valid;
        prev_rdy = resp_ready;
        prev = {resp_id, resp_err, resp_text};
      end
    end
  end
  task automatic drain(input string nm);
    int w;
    w = 0;
    while ((jq0.size() != 0 || jq1.size() != 0 || dbusy[0] || dbusy[1] || sb.size() != 0 || busy) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk(nm, w < 5000, 1);
  endtask
  initial begin : main
    int w;
    logic seen;
    logic [127:0] kc, kp[3];
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_outs", {req0_ready, req1_ready, resp_valid, resp_id, resp_err, resp_text, eng_mode, eng_kld, eng_ld, eng_key, eng_text_in, busy}, 0);
    jq0.push_back(mk(0, K0, P0));
    drain("drain_enc");
    jq1.push_back(mk(1, K0, C0));
    drain("drain_dec");
    gseq.delete();
    jq0.push_back(mk(1'($urandom), rnd128(), rnd128()));
    jq0.push_back(mk(1'($urandom), rnd128(), rnd128()));
    jq1.push_back(mk(1'($urandom), rnd128(), rnd128()));
    jq1.push_back(mk(1'($urandom), rnd128(), rnd128()));
    drain("drain_rr");
    chk("rr_count", gseq.size(), 4);
    if (gseq.size() == 4) chk("rr_order", {gseq[0], gseq[1], gseq[2], gseq[3]}, 4'b0101);
    eng_cfg = 1;
    jq0.push_back(mk(0, rnd128(), rnd128()));
    drain("drain_timeout");
    chk("idle_after_to", busy, 0);
    eng_cfg = 3;
    jq1.push_back(mk(0, rnd128(), rnd128()));
    drain("drain_done_at_limit");
    eng_cfg = 4;
    jq0.push_back(mk(1, rnd128(), rnd128()));
    drain("drain_done_late");
    repeat (4) @(negedge clk);
    eng_cfg = 0;
    rr_hold = 1;
    jq0.push_back(mk(0, rnd128(), rnd128()));
    jq1.push_back(mk(1, rnd128(), rnd128()));
    w = 0;
    while (!resp_valid && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("stall_resp", resp_valid, 1);
    repeat (20) @(negedge clk);
    chk("stall_hold", {resp_valid, req0_ready, req1_ready}, 3'b100);
    rr_hold = 0;
    drain("drain_stall");
    kc = rnd128();
    kld_cnt = 0;
    jq0.push_back(mk(1, kc, rnd128()));
    jq0.push_back(mk(1, kc, rnd128()));
    drain("drain_cache_same");
    jq1.push_back(mk(1, kc ^ 128'h1, rnd128()));
    drain("drain_cache_diff");
`ifdef AES_KEY_CACHE_EN
    chk("kld_count", kld_cnt, 2);
`else
    chk("kld_count", kld_cnt, 3);
`endif
    for (int i = 0; i < 3; i++) kp[i] = rnd128();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) != 0) jq1.push_back(mk(1'($urandom), kp[$urandom_range(0, 2)], rnd128()));
      else jq0.push_back(mk(1'($urandom), kp[$urandom_range(0, 2)], rnd128()));
    end
    drain("drain_random");
    eng_cfg = 2;
    jq0.push_back(mk(0, rnd128(), rnd128()));
    w = 0;
    while (!eng_ld && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("ld_seen", eng_ld, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_run_outs", {req0_ready, req1_ready, resp_valid, resp_id, resp_err, resp_text, eng_mode, eng_kld, eng_ld, eng_key, eng_text_in, busy}, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | resp_valid | busy;
    end
    chk("late_done_ignored", seen, 0);
    eng_cfg = 0;
    jq1.push_back(mk(0, K0, P0));
    drain("drain_after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
